// File: rtl/and_gate_if.sv
// Operand/result bundle for and_gate: the master drives A/B/in_valid/clr,
// the slave returns the AND results and the per-combination counters.
interface and_gate_if #(
  parameter int WIDTH = 1,
  parameter int CNT_W = 16
);
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             in_valid;
  logic             clr;
  logic [WIDTH-1:0] F;
  logic [WIDTH-1:0] F_q;
  logic             out_valid;
  logic             all_ones;
  logic [CNT_W-1:0] cnt_00;
  logic [CNT_W-1:0] cnt_01;
  logic [CNT_W-1:0] cnt_10;
  logic [CNT_W-1:0] cnt_11;

  modport master (
    output A, B, in_valid, clr,
    input  F, F_q, out_valid, all_ones, cnt_00, cnt_01, cnt_10, cnt_11
  );

  modport slave (
    input  A, B, in_valid, clr,
    output F, F_q, out_valid, all_ones, cnt_00, cnt_01, cnt_10, cnt_11
  );
endinterface

// File: rtl/and_gate.sv
// Bitwise AND: F/all_ones are combinational; F_q/out_valid follow one edge after an in_valid sample.
// No backpressure; in_valid alone qualifies capture and the saturating bit-0 combination counters.
module and_gate #(
  parameter int WIDTH = 1,
  parameter int CNT_W = 16
) (
  input logic        clk,
  input logic        rst_n,
  and_gate_if.slave  bus
);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0]      f;
  logic [WIDTH-1:0]      f_q_q;
  logic [WIDTH-1:0]      f_q_d;
  logic                  out_valid_q;
  logic                  out_valid_d;
  logic [3:0][CNT_W-1:0] cnt_q;
  logic [3:0][CNT_W-1:0] cnt_d;
  logic [1:0]            sel;

  assign f   = bus.A & bus.B;
  // Counter index is {A[0],B[0]}, so index 1 is cnt_01 (A=0, B=1).
  assign sel = {bus.A[0], bus.B[0]};

  always_comb begin
    f_q_d       = f_q_q;
    out_valid_d = bus.in_valid;
    if (bus.in_valid) begin
      f_q_d = f;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (bus.clr) begin
      cnt_d = '0;
    end else if (bus.in_valid && (cnt_q[sel] != CNT_MAX)) begin
      cnt_d[sel] = cnt_q[sel] + CNT_ONE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      f_q_q       <= '0;
      out_valid_q <= 1'b0;
      cnt_q       <= '0;
    end else begin
      f_q_q       <= f_q_d;
      out_valid_q <= out_valid_d;
      cnt_q       <= cnt_d;
    end
  end

  assign bus.F         = f;
  assign bus.all_ones  = &f;
  assign bus.F_q       = f_q_q;
  assign bus.out_valid = out_valid_q;
  assign bus.cnt_00    = cnt_q[0];
  assign bus.cnt_01    = cnt_q[1];
  assign bus.cnt_10    = cnt_q[2];
  assign bus.cnt_11    = cnt_q[3];
endmodule

// File: tb/tb_and_gate.sv
// Bench for and_gate: a 1-bit/16-bit-counter instance and an 8-bit/4-bit-counter instance
// driven side by side, with expectations taken from plain arithmetic on occurrence counts.
module tb_and_gate;
  logic clk;
  logic rst_n;
  int   n_vec;
  int   n_err;

  and_gate_if #(.WIDTH(1), .CNT_W(16)) if1 ();
  and_gate_if #(.WIDTH(8), .CNT_W(4))  if8 ();

  and_gate #(.WIDTH(1), .CNT_W(16)) dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));
  and_gate #(.WIDTH(8), .CNT_W(4))  dut8 (.clk(clk), .rst_n(rst_n), .bus(if8));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference state: last captured result, valid flag, raw occurrence counts since clear.
  logic [0:0] m1_fq;
  logic [7:0] m8_fq;
  logic       m_ov;
  int         raw1 [4];
  int         raw8 [4];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int sat(input int raw, input int w);
    int mx;
    mx = (1 << w) - 1;
    return (raw > mx) ? mx : raw;
  endfunction

  task automatic model_reset();
    m1_fq = '0;
    m8_fq = '0;
    m_ov  = 1'b0;
    for (int i = 0; i < 4; i++) begin
      raw1[i] = 0;
      raw8[i] = 0;
    end
  endtask

  task automatic check_comb();
    check("F1",    64'(if1.F),        64'(if1.A & if1.B));
    check("ones1", 64'(if1.all_ones), 64'(if1.A == 1'b1 && if1.B == 1'b1));
    check("F8",    64'(if8.F),        64'(if8.A & if8.B));
    check("ones8", 64'(if8.all_ones), 64'((if8.A & if8.B) == 8'hFF));
  endtask

  task automatic check_regs();
    check("Fq1",   64'(if1.F_q),       64'(m1_fq));
    check("Fq8",   64'(if8.F_q),       64'(m8_fq));
    check("ov1",   64'(if1.out_valid), 64'(m_ov));
    check("ov8",   64'(if8.out_valid), 64'(m_ov));
    check("c1_00", 64'(if1.cnt_00),    64'(sat(raw1[0], 16)));
    check("c1_01", 64'(if1.cnt_01),    64'(sat(raw1[1], 16)));
    check("c1_10", 64'(if1.cnt_10),    64'(sat(raw1[2], 16)));
    check("c1_11", 64'(if1.cnt_11),    64'(sat(raw1[3], 16)));
    check("c8_00", 64'(if8.cnt_00),    64'(sat(raw8[0], 4)));
    check("c8_01", 64'(if8.cnt_01),    64'(sat(raw8[1], 4)));
    check("c8_10", 64'(if8.cnt_10),    64'(sat(raw8[2], 4)));
    check("c8_11", 64'(if8.cnt_11),    64'(sat(raw8[3], 4)));
  endtask

  // One clock: drive on the falling edge, check comb, then check state just after the rising edge.
  task automatic cycle(input logic a1, input logic b1, input logic [7:0] a8,
                       input logic [7:0] b8, input logic v, input logic c);
    @(negedge clk);
    if1.A = a1; if1.B = b1; if8.A = a8; if8.B = b8;
    if1.in_valid = v; if8.in_valid = v;
    if1.clr = c; if8.clr = c;
    #1;
    check_comb();
    @(posedge clk);
    if (v) begin
      m1_fq = a1 & b1;
      m8_fq = a8 & b8;
    end
    m_ov = v;
    if (c) begin
      for (int i = 0; i < 4; i++) begin
        raw1[i] = 0;
        raw8[i] = 0;
      end
    end else if (v) begin
      raw1[{a1, b1}]++;
      raw8[{a8[0], b8[0]}]++;
    end
    #1;
    check_regs();
  endtask

  initial begin
    logic [1:0] tt [5];
    logic [7:0] ra;
    logic [7:0] rb;
    n_vec = 0;
    n_err = 0;
    rst_n = 1'b0;
    if1.A = '0; if1.B = '0; if1.in_valid = 1'b0; if1.clr = 1'b0;
    if8.A = '0; if8.B = '0; if8.in_valid = 1'b0; if8.clr = 1'b0;
    model_reset();
    #1;
    check_regs();

    // Truth table while held in reset: combinational path must stay live.
    tt[0] = 2'b00; tt[1] = 2'b01; tt[2] = 2'b10; tt[3] = 2'b11; tt[4] = 2'b00;
    for (int i = 0; i < 5; i++) begin
      if1.A = tt[i][1];
      if1.B = tt[i][0];
      #1;
      check("tt_F", 64'(if1.F), 64'(tt[i] == 2'b11));
      check("tt_ones", 64'(if1.all_ones), 64'(tt[i] == 2'b11));
      #9;
    end
    check_regs();
    @(negedge clk);
    rst_n = 1'b1;

    // Registered path: capture 1&1, then hold with in_valid low.
    cycle(1'b1, 1'b1, 8'hFF, 8'hFF, 1'b1, 1'b0);
    check("reg_ov_set", 64'(if1.out_valid), 64'd1);
    cycle(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
    check("reg_fq_hold", 64'(if1.F_q), 64'd1);
    check("reg_ov_drop", 64'(if1.out_valid), 64'd0);

    // Counter sequence 00,01,10,11,11 from clear, then clear with a valid sample.
    cycle(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1);
    cycle(1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0);
    cycle(1'b0, 1'b1, 8'h00, 8'h01, 1'b1, 1'b0);
    cycle(1'b1, 1'b0, 8'h01, 8'h00, 1'b1, 1'b0);
    cycle(1'b1, 1'b1, 8'h01, 8'h01, 1'b1, 1'b0);
    cycle(1'b1, 1'b1, 8'h01, 8'h01, 1'b1, 1'b0);
    check("seq_c11", 64'(if1.cnt_11), 64'd2);
    check("seq_c01", 64'(if1.cnt_01), 64'd1);
    cycle(1'b1, 1'b1, 8'hFF, 8'hFF, 1'b1, 1'b1);
    check("clr_c11", 64'(if1.cnt_11), 64'd0);
    check("clr_fq", 64'(if8.F_q), 64'hFF);

    // Wide operand patterns.
    cycle(1'b0, 1'b0, 8'hF0, 8'h3C, 1'b1, 1'b0);
    check("w8_F", 64'(if8.F_q), 64'h30);

    // Saturation on the 4-bit counters.
    for (int i = 0; i < 20; i++) begin
      cycle(1'b1, 1'b1, 8'hFF, 8'hFF, 1'b1, 1'b0);
    end
    check("sat_c11", 64'(if8.cnt_11), 64'd15);
    check("sat_c00", 64'(if8.cnt_00), 64'd1);

    // Randomized traffic with occasional clears.
    for (int i = 0; i < 400; i++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      cycle(1'($urandom), 1'($urandom), ra, (($urandom_range(0, 7) == 0) ? 8'hFF : rb),
            1'($urandom_range(0, 3) != 0), ($urandom_range(0, 40) == 0));
    end

    // Asynchronous reset between edges with state loaded.
    cycle(1'b1, 1'b1, 8'hFF, 8'hFF, 1'b1, 1'b0);
    @(negedge clk);
    if1.in_valid = 1'b0; if8.in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_regs();
    check_comb();
    check("ar_F8", 64'(if8.F), 64'hFF);
    @(negedge clk);
    rst_n = 1'b1;
    cycle(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
    cycle(1'b1, 1'b1, 8'h5A, 8'h0F, 1'b1, 1'b0);
    check("post_rst_ov", 64'(if8.out_valid), 64'd1);
    check("post_rst_fq", 64'(if8.F_q), 64'h0A);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/and_gate.md
AND_GATE -- requirements
Module: and_gate

Parameters
REQ-001 WIDTH, default 1, operand/result bit width (legal 1..64).
REQ-002 CNT_W, default 16, width of each input-combination counter (legal 4..32).

Interface
REQ-003 clk  input  1  rising-edge clock for all sequential state.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low; synchronous deassert is the integrator's job.
REQ-005 F  output  WIDTH  combinational bitwise AND result.
REQ-006 A  input  WIDTH  operand A.
REQ-007 B  input  WIDTH  operand B.
REQ-008 in_valid  input  1  A/B sample qualifier for registered path and counters.
REQ-009 F_q  output  WIDTH  registered AND result.
REQ-010 out_valid  output  1  F_q holds a valid sample.
REQ-011 all_ones  output  1  combinational reduction-AND of F.
REQ-012 clr  input  1  synchronous counter clear.
REQ-013 cnt_00, cnt_01, cnt_10, cnt_11  output  CNT_W each  counts of bit-0 input combinations {A[0],B[0]}.

Function
REQ-014 F SHALL equal A & B bitwise at all times, zero latency, independent of clk, rst_n, in_valid.
REQ-015 all_ones SHALL be 1 exactly when every bit of F is 1.
REQ-016 When in_valid=1 at a rising clk edge, F_q SHALL take A & B and out_valid SHALL be 1 after that edge (latency 1 cycle).
REQ-017 When in_valid=0 at a rising edge, out_valid SHALL be 0 and F_q SHALL hold its prior value.
REQ-018 On each rising edge with in_valid=1 and clr=0, exactly one counter selected by {A[0],B[0]} (00,01,10,11) SHALL increment by 1.
REQ-019 Counters SHALL saturate at 2^CNT_W-1; no wrap-around.
REQ-020 clr=1 at a rising edge SHALL zero all four counters; clr SHALL take priority over a simultaneous increment.
REQ-021 clr SHALL NOT affect F, F_q, out_valid, or all_ones.
REQ-022 X/undriven operands need not be handled; inputs are assumed 0/1 by integration contract.

Reset
REQ-023 rst_n=0 SHALL immediately (asynchronously) force F_q=0, out_valid=0, all counters=0.
REQ-024 Reset SHALL NOT gate F or all_ones; combinational path remains live during reset.
REQ-025 Reset asserted mid-operation SHALL discard any pending sample; first valid sample after release appears on out_valid one edge after capture.

Verification
REQ-026 Truth table, WIDTH=1, 10 ns steps: (A,B)=00,01,10,11,00 -> F=0,0,0,1,0 with no clock edge required; all_ones tracks F.
REQ-027 Registered path: in_valid=1, A=1,B=1 at edge n -> F_q=1, out_valid=1 after edge n; in_valid=0 at n+1 -> out_valid=0, F_q stays 1.
REQ-028 Counters: apply 00,01,10,11,11 with in_valid=1 on five edges -> cnt_00=1, cnt_01=1, cnt_10=1, cnt_11=2; then clr=1 with in_valid=1 -> all counters 0.
REQ-029 Saturation, CNT_W=4: 20 valid samples of 11 -> cnt_11=15, others 0.
REQ-030 Async reset: drop rst_n between clock edges with F_q=1, counters nonzero -> F_q, out_valid, counters 0 immediately; F still equals A & B.
REQ-031 WIDTH=8: A=0xF0, B=0x3C -> F=0x30, all_ones=0; A=B=0xFF -> F=0xFF, all_ones=1.
